// File: rtl/counter_monitor_if.sv
// Sample/status bundle between a 2-bit counter consumer and the counter_monitor checker.
interface counter_monitor_if #(
    parameter int ERR_CNT_W = 8
);
    logic                 en;
    logic                 q0;
    logic                 q1;
    logic                 err_clr;
    logic                 locked;
    logic                 err_pulse;
    logic                 wrap_pulse;
    logic [ERR_CNT_W-1:0] err_count;

    modport master (
        output en, q0, q1, err_clr,
        input  locked, err_pulse, wrap_pulse, err_count
    );

    modport slave (
        input  en, q0, q1, err_clr,
        output locked, err_pulse, wrap_pulse, err_count
    );
endinterface

// File: rtl/counter_monitor.sv
// Checks that each sampled 2-bit count is the legal successor of the previous one,
// acquires lock after a run of good steps, and reports errors and wrap-around.
module counter_monitor #(
    parameter int ERR_CNT_W  = 8,
    parameter int LOCK_COUNT = 4,
    parameter int DIR        = 0
) (
    input  logic              clk,
    input  logic              RESET,
    counter_monitor_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_N    = 4'(LOCK_COUNT);
    localparam logic [1:0] STEP      = (DIR != 0) ? 2'd3 : 2'd1;
    localparam logic [1:0] WRAP_FROM = (DIR != 0) ? 2'd0 : 2'd3;
    localparam logic [1:0] WRAP_TO   = (DIR != 0) ? 2'd3 : 2'd0;

    state_t               r_state;
    logic [1:0]           r_prev;
    logic [3:0]           r_good_cnt;
    logic                 r_locked;
    logic                 r_err_pulse;
    logic                 r_wrap_pulse;
    logic [ERR_CNT_W-1:0] r_err_count;

    state_t               w_state_nxt;
    logic [1:0]           w_prev_nxt;
    logic [3:0]           w_good_cnt_nxt;
    logic                 w_locked_nxt;
    logic                 w_err_nxt;
    logic                 w_wrap_nxt;
    logic [ERR_CNT_W-1:0] w_err_count_nxt;
    logic [1:0]           w_v;
    logic [1:0]           w_exp;
    logic                 w_good;
    logic                 w_wrap_step;

    assign w_v         = {bus.q1, bus.q0};
    assign w_exp       = r_prev + STEP;
    assign w_good      = (w_v == w_exp);
    assign w_wrap_step = (r_prev == WRAP_FROM) && (w_v == WRAP_TO);

    // NOTE: every output of this block gets a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        w_state_nxt     = r_state;
        w_prev_nxt      = r_prev;
        w_good_cnt_nxt  = r_good_cnt;
        w_locked_nxt    = r_locked;
        w_err_nxt       = 1'b0;
        w_wrap_nxt      = 1'b0;
        w_err_count_nxt = r_err_count;

        if (bus.en) begin
            w_prev_nxt = w_v;
            case (r_state)
                IDLE: begin
                    w_good_cnt_nxt = 4'd0;
                    w_state_nxt    = ACQ;
                end
                ACQ: begin
                    if (w_good) begin
                        w_wrap_nxt     = w_wrap_step;
                        w_good_cnt_nxt = r_good_cnt + 4'd1;
                        if (r_good_cnt + 4'd1 == LOCK_N) begin
                            w_state_nxt  = LOCKED;
                            w_locked_nxt = 1'b1;
                        end
                    end else begin
                        w_good_cnt_nxt = 4'd0;
                    end
                end
                LOCKED: begin
                    if (w_good) begin
                        w_wrap_nxt = w_wrap_step;
                    end else begin
                        // The bad sample becomes prev, so reacquisition starts from it.
                        w_err_nxt      = 1'b1;
                        w_locked_nxt   = 1'b0;
                        w_good_cnt_nxt = 4'd0;
                        w_state_nxt    = ACQ;
                    end
                end
                default: begin
                    w_state_nxt  = IDLE;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end

        // A clear colliding with an error leaves that error counted.
        if (w_err_nxt) begin
            if (bus.err_clr)
                w_err_count_nxt = ERR_CNT_W'(1);
            else if (r_err_count != '1)
                w_err_count_nxt = r_err_count + ERR_CNT_W'(1);
        end else if (bus.err_clr) begin
            w_err_count_nxt = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_prev       <= 2'd0;
            r_good_cnt   <= 4'd0;
            r_locked     <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_wrap_pulse <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_prev       <= w_prev_nxt;
            r_good_cnt   <= w_good_cnt_nxt;
            r_locked     <= w_locked_nxt;
            r_err_pulse  <= w_err_nxt;
            r_wrap_pulse <= w_wrap_nxt;
            r_err_count  <= w_err_count_nxt;
        end
    end

    assign bus.locked     = r_locked;
    assign bus.err_pulse  = r_err_pulse;
    assign bus.wrap_pulse = r_wrap_pulse;
    assign bus.err_count  = r_err_count;
endmodule
